// File: rtl/display_sequencer_if.sv
// Message handshake bundle between game logic and display_sequencer.
interface display_sequencer_if;
    logic        msg_valid;
    logic        msg_ready;
    logic [31:0] msg_bcd;
    logic [7:0]  msg_blank;
    logic        msg_abort;

    modport master (
        output msg_valid,
        output msg_bcd,
        output msg_blank,
        output msg_abort,
        input  msg_ready
    );

    modport slave (
        input  msg_valid,
        input  msg_bcd,
        input  msg_blank,
        input  msg_abort,
        output msg_ready
    );
endinterface

// File: rtl/display_sequencer.sv
// Shares the 8-digit display between score digits and timed blinking messages.
// Optional LEADING_ZERO_BLANK_EN auto-blanks leading zero score digits.
module display_sequencer #(
    parameter int HOLD_CYCLES  = 32,
    parameter int BLINK_CYCLES = 4
) (
    input  logic                clock,
    input  logic                reset_L,
    input  logic [31:0]         score_bcd,
    input  logic [7:0]          score_blank,
    display_sequencer_if.slave  msg,
    output logic                busy,
    output logic [31:0]         bcd_out,
    output logic [7:0]          blank_out
);

    typedef enum logic [1:0] {
        SCORE,
        MSG_ON,
        MSG_OFF
    } state_t;

    localparam logic [23:0] HOLD_LD  = 24'(HOLD_CYCLES - 1);
    localparam logic [23:0] BLINK_LD = 24'(BLINK_CYCLES - 1);

    state_t      state;
    logic [23:0] hold_cnt;
    logic [23:0] blink_cnt;
    logic [31:0] msg_bcd_q;
    logic [7:0]  msg_blank_q;
    logic [7:0]  score_blank_eff;

    assign msg.msg_ready = reset_L && (state == SCORE);

`ifdef LEADING_ZERO_BLANK_EN
    logic [7:0] lz_mask;
    logic       zero_run;

    // Walk down from the top digit; digit0 always stays visible.
    always_comb begin
        lz_mask  = 8'h00;
        zero_run = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            zero_run   = zero_run && (score_bcd[i*4 +: 4] == 4'h0);
            lz_mask[i] = zero_run;
        end
    end

    assign score_blank_eff = score_blank | lz_mask;
`else
    assign score_blank_eff = score_blank;
`endif

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state       <= SCORE;
            busy        <= 1'b0;
            hold_cnt    <= 24'h0;
            blink_cnt   <= 24'h0;
            msg_bcd_q   <= 32'h0;
            msg_blank_q <= 8'h0;
            bcd_out     <= 32'h0;
            blank_out   <= 8'hFF;
        end else begin
            case (state)
                SCORE: begin
                    bcd_out   <= score_bcd;
                    blank_out <= score_blank_eff;
                    if (msg.msg_valid) begin
                        msg_bcd_q   <= msg.msg_bcd;
                        msg_blank_q <= msg.msg_blank;
                        state       <= MSG_ON;
                        busy        <= 1'b1;
                        hold_cnt    <= HOLD_LD;
                        blink_cnt   <= BLINK_LD;
                        bcd_out     <= msg.msg_bcd;
                        blank_out   <= msg.msg_blank;
                    end
                end
                MSG_ON, MSG_OFF: begin
                    // Abort and hold expiry both win over a blink toggle.
                    if (msg.msg_abort || hold_cnt == 24'h0) begin
                        state     <= SCORE;
                        busy      <= 1'b0;
                        bcd_out   <= score_bcd;
                        blank_out <= score_blank_eff;
                    end else begin
                        hold_cnt <= hold_cnt - 24'h1;
                        bcd_out  <= msg_bcd_q;
                        if (blink_cnt == 24'h0) begin
                            blink_cnt <= BLINK_LD;
                            if (state == MSG_ON) begin
                                state     <= MSG_OFF;
                                blank_out <= 8'hFF;
                            end else begin
                                state     <= MSG_ON;
                                blank_out <= msg_blank_q;
                            end
                        end else begin
                            blink_cnt <= blink_cnt - 24'h1;
                            blank_out <= (state == MSG_ON) ? msg_blank_q : 8'hFF;
                        end
                    end
                end
                default: begin
                    state <= SCORE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
